// File: rtl/seq_alu_pkg.sv
// Shared opcodes and handshake FSM state encoding for seq_alu.
package seq_alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SLL  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_MUL  = 4'd12;
    localparam logic [3:0] ALU_DIVU = 4'd13;
    localparam logic [3:0] ALU_REMU = 4'd14;
    localparam logic [3:0] ALU_RSVD = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

endpackage

// File: rtl/seq_alu_iter.sv
// Shared iteration unit: shift-add multiply and, with SEQ_ALU_DIV_EN defined,
// restoring divide. One bit per cycle; done_o flags the final iteration.
module seq_alu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
`ifdef SEQ_ALU_DIV_EN
    input  logic             div_i,
    input  logic             rem_i,
`endif
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [SHW:0] CntLoad = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CntOne  = (SHW+1)'(1);

    logic [SHW:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;

`ifdef SEQ_ALU_DIV_EN
    logic         div_q, rem_q;
    logic [WIDTH:0] rem_sh, rem_sub;
    logic           rem_ge;
`endif

    always_comb begin
        acc_d = acc_q;
        opa_d = opa_q;
        opb_d = opb_q;
        cnt_d = cnt_q;
`ifdef SEQ_ALU_DIV_EN
        // acc holds the partial remainder, opa shifts dividend out and quotient in
        rem_sh  = {acc_q, opa_q[WIDTH-1]};
        rem_ge  = rem_sh >= {1'b0, opb_q};
        rem_sub = rem_sh - {1'b0, opb_q};
`endif
        if (start_i) begin
            acc_d = '0;
            opa_d = src1_i;
            opb_d = src2_i;
            cnt_d = CntLoad;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntOne;
`ifdef SEQ_ALU_DIV_EN
            if (div_q) begin
                acc_d = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                opa_d = {opa_q[WIDTH-2:0], rem_ge};
            end else begin
                acc_d = acc_q + (opa_q[0] ? opb_q : '0);
                opa_d = opa_q >> 1;
                opb_d = opb_q << 1;
            end
`else
            acc_d = acc_q + (opa_q[0] ? opb_q : '0);
            opa_d = opa_q >> 1;
            opb_d = opb_q << 1;
`endif
        end
    end

    assign done_o = (cnt_q == CntOne);

    // Result reflects this cycle's iteration so the top can latch it on done_o.
`ifdef SEQ_ALU_DIV_EN
    assign result_o = (div_q && !rem_q) ? opa_d : acc_d;
`else
    assign result_o = acc_d;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            acc_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q <= 1'b0;
            rem_q <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
`ifdef SEQ_ALU_DIV_EN
            if (start_i) begin
                div_q <= div_i;
                rem_q <= rem_i;
            end
`endif
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops plus iterative MUL (and DIVU/REMU when
// SEQ_ALU_DIV_EN is defined; otherwise opcodes 13/14 act as reserved).
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             valid_o,
    input  logic             ready_i
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic             is_multi;
    logic             iter_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;

    assign shamt = src2_i[SHW-1:0];

`ifdef SEQ_ALU_DIV_EN
    assign is_multi = (ctrl_i == ALU_MUL) || (ctrl_i == ALU_DIVU) || (ctrl_i == ALU_REMU);
`else
    assign is_multi = (ctrl_i == ALU_MUL);
`endif

    always_comb begin
        alu_res = '0;
        case (ctrl_i)
            ALU_AND:  alu_res = src1_i & src2_i;
            ALU_OR:   alu_res = src1_i | src2_i;
            ALU_ADD:  alu_res = src1_i + src2_i;
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src1_i < src2_i};
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
            ALU_XOR:  alu_res = src1_i ^ src2_i;
            ALU_SUB:  alu_res = src1_i - src2_i;
            ALU_NOR:  alu_res = ~(src1_i | src2_i);
            ALU_SRA:  alu_res = $unsigned($signed(src1_i) >>> shamt);
            ALU_SRL:  alu_res = src1_i >> shamt;
            ALU_SLL:  alu_res = src1_i << shamt;
            ALU_LUI:  alu_res = src2_i << (WIDTH / 2);
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        iter_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    if (is_multi) begin
                        iter_start = 1'b1;
                        state_d    = S_BUSY;
                    end else begin
                        result_d = alu_res;
                        state_d  = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                if (iter_done) begin
                    result_d = iter_result;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign valid_o  = (state_q == S_DONE);
    assign result_o = result_q;
    assign zero_o   = (result_q == '0);

    seq_alu_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (iter_start),
`ifdef SEQ_ALU_DIV_EN
        .div_i    ((ctrl_i == ALU_DIVU) || (ctrl_i == ALU_REMU)),
        .rem_i    (ctrl_i == ALU_REMU),
`endif
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .done_o   (iter_done),
        .result_o (iter_result)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed table, hand sequences
// for multi-cycle corners, and random ops against an arithmetic model.
module tb_seq_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  src1, src2;
    logic [3:0]    ctrl;
    logic          valid_in;
    logic          ready_out;
    logic [W-1:0]  result;
    logic          zero;
    logic          valid_out;
    logic          ready_in;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .src1_i   (src1),
        .src2_i   (src2),
        .ctrl_i   (ctrl),
        .valid_i  (valid_in),
        .ready_o  (ready_out),
        .result_o (result),
        .zero_o   (zero),
        .valid_o  (valid_out),
        .ready_i  (ready_in)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        int sh;
        sh = int'(b % 32);
        p  = 64'(a) * 64'(b);
        case (op)
            4'd0:  model = a & b;
            4'd1:  model = a | b;
            4'd2:  model = a + b;
            4'd3:  model = (a < b) ? 32'd1 : 32'd0;
            4'd4:  model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:  model = a ^ b;
            4'd6:  model = a - b;
            4'd7:  model = ~(a | b);
            4'd8:  model = 32'($signed(a) >>> sh);
            4'd9:  model = a >> sh;
            4'd10: model = a << sh;
            4'd11: model = b << 16;
            4'd12: model = p[31:0];
`ifdef SEQ_ALU_DIV_EN
            4'd13: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14: model = (b == 0) ? a : a % b;
`endif
            default: model = 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
        if (op == 4'd12 || op == 4'd13 || op == 4'd14) return W + 1;
`else
        if (op == 4'd12) return W + 1;
`endif
        return 1;
    endfunction

    // Issues one request, scrambles inputs after acceptance, returns when valid_o is seen.
    // cyc counts clock edges from the accepting edge (inclusive) to the first valid_o.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output int cyc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready_out && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ctrl = op; src1 = a; src2 = b; valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        src1 = $urandom; src2 = $urandom; ctrl = 4'($urandom);
        cyc = 1;
        @(negedge clk);
        while (!valid_out && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        res = result;
        z   = zero;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] res, held;
        logic        z, busy_ok, quiet;
        int          cyc;
        logic [3:0]  op;
        logic [31:0] a, b;

        vecs.push_back('{"add_wrap", 4'd2,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1});
        vecs.push_back('{"sub_zero", 4'd6,  32'h5,         32'h5,         32'h0,         1});
        vecs.push_back('{"slt",      4'd4,  32'hFFFF_FFFF, 32'h1,         32'h1,         1});
        vecs.push_back('{"sltu",     4'd3,  32'hFFFF_FFFF, 32'h1,         32'h0,         1});
        vecs.push_back('{"sra",      4'd8,  32'h8000_0000, 32'h24,        32'hF800_0000, 1});
        vecs.push_back('{"lui",      4'd11, 32'hDEAD_BEEF, 32'h1234,      32'h1234_0000, 1});
        vecs.push_back('{"and",      4'd0,  32'hF0F0,      32'hFF00,      32'hF000,      1});
        vecs.push_back('{"or",       4'd1,  32'hF0F0,      32'h0F0F,      32'hFFFF,      1});
        vecs.push_back('{"xor",      4'd5,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1});
        vecs.push_back('{"nor",      4'd7,  32'h0,         32'h0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{"srl",      4'd9,  32'h8000_0000, 32'h1F,        32'h1,         1});
        vecs.push_back('{"sll",      4'd10, 32'h1,         32'h3F,        32'h8000_0000, 1});
        vecs.push_back('{"rsvd",     4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1});
        vecs.push_back('{"mul",      4'd12, 32'h1_0000,    32'h1_0001,    32'h1_0000,    33});
        vecs.push_back('{"mul_ones", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         33});
`ifdef SEQ_ALU_DIV_EN
        vecs.push_back('{"divu",     4'd13, 32'd100,       32'd7,         32'd14,        33});
        vecs.push_back('{"remu",     4'd14, 32'd100,       32'd7,         32'd2,         33});
        vecs.push_back('{"divu_z",   4'd13, 32'd12345,     32'd0,         32'hFFFF_FFFF, 33});
        vecs.push_back('{"remu_z",   4'd14, 32'd9,         32'd0,         32'd9,         33});
`else
        vecs.push_back('{"divu_off", 4'd13, 32'd100,       32'd7,         32'd0,         1});
        vecs.push_back('{"remu_off", 4'd14, 32'd100,       32'd7,         32'd0,         1});
`endif

        rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        src1 = '0; src2 = '0; ctrl = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(ready_out), 32'd1);
        check("reset_valid", 32'(valid_out), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_zero", 32'(zero), 32'd1);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, cyc);
            check({vecs[i].name, "_res"}, res, vecs[i].exp);
            check({vecs[i].name, "_zero"}, 32'(z), (vecs[i].exp == 0) ? 32'd1 : 32'd0);
            check({vecs[i].name, "_lat"}, 32'(cyc), 32'(vecs[i].lat));
        end

        // MUL with a competing request held during BUSY
        @(negedge clk);
        ctrl = 4'd12; src1 = 32'h1_0000; src2 = 32'h1_0001; valid_in = 1'b1;
        @(posedge clk);
        #1;
        ctrl = 4'd2; src1 = 32'd1; src2 = 32'd1;
        cyc = 1; busy_ok = 1'b1;
        @(negedge clk);
        while (!valid_out && cyc < 100) begin
            if (ready_out) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        valid_in = 1'b0;
        check("mulbusy_lat", 32'(cyc), 32'd33);
        check("mulbusy_res", result, 32'h1_0000);
        check("mulbusy_ready_low", 32'(busy_ok), 32'd1);
        @(negedge clk);
        check("mulbusy_idle_ready", 32'(ready_out), 32'd1);
        check("mulbusy_idle_valid", 32'(valid_out), 32'd0);

        // Backpressure in DONE
        ready_in = 1'b0;
        run_op(4'd2, 32'h11, 32'h22, held, z, cyc);
        check("bp_first", held, 32'h33);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid_hold", 32'(valid_out), 32'd1);
            check("bp_result_hold", result, 32'h33);
            check("bp_ready_low", 32'(ready_out), 32'd0);
        end
        ready_in = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(valid_out), 32'd0);
        check("bp_release_ready", 32'(ready_out), 32'd1);

        // Reset in the middle of a MUL
        @(negedge clk);
        ctrl = 4'd12; src1 = 32'd3; src2 = 32'd5; valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_valid", 32'(valid_out), 32'd0);
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_ready", 32'(ready_out), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_out) quiet = 1'b0;
        end
        check("rst_abort_no_result", 32'(quiet), 32'd1);
        run_op(4'd2, 32'd2, 32'd3, res, z, cyc);
        check("post_rst_add", res, 32'd5);
        check("post_rst_lat", 32'(cyc), 32'd1);

        // Random ops against the model
        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            run_op(op, a, b, res, z, cyc);
            check($sformatf("rand%0d_op%0d_res", n, op), res, model(op, a, b));
            check($sformatf("rand%0d_op%0d_lat", n, op), 32'(cyc), 32'(model_lat(op)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
